// File: rtl/pe_psum_packetizer_if.sv
// Psum-in / packet-out handshake bundle for pe_psum_packetizer.
// master: the packetizer side; slave: the PE datapath plus router port side.
interface pe_psum_packetizer_if #(
    parameter int PSUM_WIDTH   = 8,
    parameter int PACKET_WIDTH = 39
);
    logic                    psum_valid;
    logic                    psum_ready;
    logic [PSUM_WIDTH-1:0]   psum_data;
    logic                    flush;
    logic                    pkt_valid;
    logic                    pkt_ready;
    logic [PACKET_WIDTH-1:0] pkt_data;

    modport master (
        input  psum_valid, psum_data, flush, pkt_ready,
        output psum_ready, pkt_valid, pkt_data
    );

    modport slave (
        output psum_valid, psum_data, flush, pkt_ready,
        input  psum_ready, pkt_valid, pkt_data
    );
endinterface

// File: rtl/pe_psum_packetizer.sv
// Packs three psums plus src/dest router addresses into one NoC packet.
// Optional `PSUM_PKT_SEQ_EN adds {count, seq} tag bits at pkt_data[35:32].
module pe_psum_packetizer #(
    parameter int PACKET_WIDTH = 39,
    parameter int PSUM_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int SRC_ADDR     = 4,
    parameter int DEST_ADDR    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pe_psum_packetizer_if.master  bus,
    output logic                  busy
);
    localparam int NUM_SLOTS = 3;
    localparam int PAD_W     = PACKET_WIDTH - 2*ADDR_WIDTH - NUM_SLOTS*PSUM_WIDTH;

    typedef enum logic {COLLECT, SEND} state_t;

    state_t                                 state;
    logic [1:0]                             count;
    logic [NUM_SLOTS-1:0][PSUM_WIDTH-1:0]   slot;
`ifdef PSUM_PKT_SEQ_EN
    logic [1:0]                             seq;
`endif

    logic                                   accept;
    logic                                   go_send;
    logic [1:0]                             count_nxt;
    logic [NUM_SLOTS-1:0][PSUM_WIDTH-1:0]   slot_nxt;
    logic [PAD_W-1:0]                       pad;
    logic [PACKET_WIDTH-1:0]                pkt_nxt;

    // psum_ready is only high in COLLECT, so accept never fires in SEND
    always_comb begin
        accept    = (state == COLLECT) && bus.psum_ready && bus.psum_valid;
        count_nxt = count + 2'(accept);
        slot_nxt  = slot;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (accept && count == 2'(i)) slot_nxt[i] = bus.psum_data;
        go_send   = (state == COLLECT) && bus.psum_ready &&
                    ((accept && count == 2'd2) || (bus.flush && count_nxt != 2'd0));
`ifdef PSUM_PKT_SEQ_EN
        pad       = {{(PAD_W-4){1'b0}}, count_nxt, seq};
`else
        pad       = '0;
`endif
        pkt_nxt   = {pad, slot_nxt[2], slot_nxt[1], slot_nxt[0],
                     ADDR_WIDTH'(SRC_ADDR), ADDR_WIDTH'(DEST_ADDR)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= COLLECT;
            count          <= 2'd0;
            slot           <= '0;
            bus.psum_ready <= 1'b0;
            bus.pkt_valid  <= 1'b0;
            bus.pkt_data   <= '0;
            busy           <= 1'b0;
`ifdef PSUM_PKT_SEQ_EN
            seq            <= 2'd0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    count <= count_nxt;
                    slot  <= slot_nxt;
                    if (go_send) begin
                        state          <= SEND;
                        bus.psum_ready <= 1'b0;
                        bus.pkt_valid  <= 1'b1;
                        bus.pkt_data   <= pkt_nxt;
                        busy           <= 1'b1;
                    end else begin
                        bus.psum_ready <= 1'b1;
                        busy           <= (count_nxt != 2'd0);
                    end
                end
                SEND: begin
                    // Hold the packet until the router takes it; flush is ignored here.
                    if (bus.pkt_ready) begin
                        state          <= COLLECT;
                        count          <= 2'd0;
                        slot           <= '0;
                        bus.pkt_valid  <= 1'b0;
                        bus.pkt_data   <= '0;
                        bus.psum_ready <= 1'b1;
                        busy           <= 1'b0;
`ifdef PSUM_PKT_SEQ_EN
                        seq            <= seq + 2'd1;
`endif
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_psum_packetizer.sv
// Scoreboard bench for pe_psum_packetizer: two PEs (SRC 4 and SRC 1) sharing clk/rst_n.
module tb_pe_psum_packetizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy0, busy1;
    always #5 clk = ~clk;

    pe_psum_packetizer_if #(.PSUM_WIDTH(8), .PACKET_WIDTH(39)) if0 ();
    pe_psum_packetizer_if #(.PSUM_WIDTH(8), .PACKET_WIDTH(39)) if1 ();

    pe_psum_packetizer #(.PACKET_WIDTH(39), .PSUM_WIDTH(8), .ADDR_WIDTH(4),
                         .SRC_ADDR(4), .DEST_ADDR(3))
        u_pe0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0));
    pe_psum_packetizer #(.PACKET_WIDTH(39), .PSUM_WIDTH(8), .ADDR_WIDTH(4),
                         .SRC_ADDR(1), .DEST_ADDR(3))
        u_pe1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

    int n_pass = 0;
    int n_total = 0;
    logic [38:0] q0[$];
    logic [38:0] q1[$];

    logic [31:0] t6_low [5] = '{32'h12111043, 32'h15141343, 32'h18171643,
                                32'h1B1A1943, 32'h1E1D1C43};
    logic [1:0]  t6_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Upper tag bits: {3'b0, count, seq} with the option on, zero otherwise
    function automatic logic [6:0] hdr(input logic [1:0] c, input logic [1:0] s);
        logic [6:0] h;
        h = {3'b000, c, s};
`ifndef PSUM_PKT_SEQ_EN
        h = 7'd0;
`endif
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Call at a negedge; returns at the negedge after the psum is accepted
    task automatic push0(input logic [7:0] v, input logic fl);
        int n;
        n = 0;
        if0.psum_valid = 1'b1;
        if0.psum_data  = v;
        if0.flush      = fl;
        while (!if0.psum_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            n_total++;
            $display("FAIL pe0 psum accept timeout: psum_ready 0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
        if0.psum_valid = 1'b0;
        if0.psum_data  = 8'hEE;
        if0.flush      = 1'b0;
    endtask

    initial begin
        if0.psum_valid = 1'b0; if0.psum_data = 8'h00; if0.flush = 1'b0; if0.pkt_ready = 1'b1;
        if1.psum_valid = 1'b0; if1.psum_data = 8'h00; if1.flush = 1'b0; if1.pkt_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                #2;
                if (rst_n && if0.pkt_valid && if0.pkt_ready) begin
                    if (q0.size() == 0) begin
                        n_total++;
                        $display("FAIL pe0 unexpected packet: got %0h, expected none", if0.pkt_data);
                    end else check("pe0 packet", 64'(if0.pkt_data), 64'(q0.pop_front()));
                end
                if (rst_n && if1.pkt_valid && if1.pkt_ready) begin
                    if (q1.size() == 0) begin
                        n_total++;
                        $display("FAIL pe1 unexpected packet: got %0h, expected none", if1.pkt_data);
                    end else check("pe1 packet", 64'(if1.pkt_data), 64'(q1.pop_front()));
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: time limit reached, expected $finish earlier");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        #1;
        check("reset pkt_valid", 64'(if0.pkt_valid), 0);
        check("reset psum_ready", 64'(if0.psum_ready), 0);
        check("reset busy", 64'(busy0), 0);
        check("reset pkt_data", 64'(if0.pkt_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("psum_ready after reset", 64'(if0.psum_ready), 1);

        // T1: full packet, router always ready
        q0.push_back({hdr(2'd3, 2'd0), 32'h33221143});
        push0(8'h11, 1'b0);
        push0(8'h22, 1'b0);
        push0(8'h33, 1'b0);
        check("t1 pkt_valid in SEND", 64'(if0.pkt_valid), 1);
        check("t1 psum_ready in SEND", 64'(if0.psum_ready), 0);
        check("t1 busy in SEND", 64'(busy0), 1);
        @(negedge clk);
        check("t1 pkt_valid one cycle", 64'(if0.pkt_valid), 0);
        check("t1 psum_ready back", 64'(if0.psum_ready), 1);

        // T3 on PE1: single psum flushed, flush with same-cycle accept, two psums flushed
        q1.push_back({hdr(2'd1, 2'd0), 32'h0000A513});
        if1.psum_valid = 1'b1; if1.psum_data = 8'hA5;
        @(negedge clk);
        if1.psum_valid = 1'b0; if1.psum_data = 8'hEE; if1.flush = 1'b1;
        @(negedge clk);
        if1.flush = 1'b0;
        check("t3 pe1 pkt_valid", 64'(if1.pkt_valid), 1);
        check("t3 pe1 psum_ready", 64'(if1.psum_ready), 0);
        @(negedge clk);
        check("t3 pe1 pkt_valid dropped", 64'(if1.pkt_valid), 0);
        q1.push_back({hdr(2'd1, 2'd1), 32'h00005A13});
        if1.psum_valid = 1'b1; if1.psum_data = 8'h5A; if1.flush = 1'b1;
        @(negedge clk);
        if1.psum_valid = 1'b0; if1.psum_data = 8'hEE; if1.flush = 1'b0;
        @(negedge clk);
        q1.push_back({hdr(2'd2, 2'd2), 32'h00CCBB13});
        if1.psum_valid = 1'b1; if1.psum_data = 8'hBB;
        @(negedge clk);
        if1.psum_data = 8'hCC;
        @(negedge clk);
        if1.psum_valid = 1'b0; if1.psum_data = 8'hEE; if1.flush = 1'b1;
        @(negedge clk);
        if1.flush = 1'b0;
        repeat (2) @(negedge clk);

        // T2: router stalls; packet held, a psum offered waits, flush in SEND ignored
        if0.pkt_ready = 1'b0;
        push0(8'h11, 1'b0);
        push0(8'h22, 1'b0);
        push0(8'h33, 1'b0);
        q0.push_back({hdr(2'd3, 2'd1), 32'h33221143});
        q0.push_back({hdr(2'd3, 2'd2), 32'h66554443});
        if0.psum_valid = 1'b1; if0.psum_data = 8'h44;
        for (int i = 0; i < 6; i++) begin
            check("t2 pkt_valid held", 64'(if0.pkt_valid), 1);
            check("t2 pkt_data stable", 64'(if0.pkt_data), 64'({hdr(2'd3, 2'd1), 32'h33221143}));
            check("t2 psum_ready low", 64'(if0.psum_ready), 0);
            if0.flush = (i == 2);
            if (i == 5) if0.pkt_ready = 1'b1;
            @(negedge clk);
        end
        check("t2 pkt_valid after handshake", 64'(if0.pkt_valid), 0);
        check("t2 psum_ready after handshake", 64'(if0.psum_ready), 1);
        @(negedge clk);
        push0(8'h55, 1'b0);
        push0(8'h66, 1'b0);
        repeat (2) @(negedge clk);

        // T4: flush with nothing collected, then flush alongside the third psum
        if0.flush = 1'b1;
        @(negedge clk);
        if0.flush = 1'b0;
        check("t4 empty flush no packet", 64'(if0.pkt_valid), 0);
        check("t4 empty flush not busy", 64'(busy0), 0);
        @(negedge clk);
        check("t4 empty flush still idle", 64'(if0.pkt_valid), 0);
        q0.push_back({hdr(2'd3, 2'd3), 32'h07060543});
        push0(8'h05, 1'b0);
        push0(8'h06, 1'b0);
        push0(8'h07, 1'b1);
        check("t4 full+flush pkt_valid", 64'(if0.pkt_valid), 1);
        repeat (2) @(negedge clk);
        check("t4 single packet only", 64'(if0.pkt_valid), 0);

        // T5: reset while holding a packet; it must vanish without residue
        if0.pkt_ready = 1'b0;
        push0(8'h81, 1'b0);
        push0(8'h82, 1'b0);
        push0(8'h83, 1'b0);
        check("t5 in SEND before reset", 64'(if0.pkt_valid), 1);
        #4 rst_n = 1'b0;
        #1;
        check("t5 reset pkt_valid", 64'(if0.pkt_valid), 0);
        check("t5 reset pkt_data", 64'(if0.pkt_data), 0);
        check("t5 reset psum_ready", 64'(if0.psum_ready), 0);
        check("t5 reset busy", 64'(busy0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        if0.pkt_ready = 1'b1;
        @(negedge clk);
        q0.push_back({hdr(2'd3, 2'd0), 32'h03020143});
        push0(8'h01, 1'b0);
        push0(8'h02, 1'b0);
        push0(8'h03, 1'b0);
        repeat (2) @(negedge clk);

        // T6: five back-to-back full packets from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) q0.push_back({hdr(2'd3, t6_seq[k]), t6_low[k]});
        for (int i = 0; i < 15; i++) push0(8'h10 + 8'(i), 1'b0);
        repeat (4) @(negedge clk);

        check("pe0 scoreboard drained", 64'(q0.size()), 0);
        check("pe1 scoreboard drained", 64'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
